reservation_station: RTL and testbench

//  Parametrised unified reservation station between rename and the functional units (FUs).

---
 rtl/reservation_station_pkg.sv | 40 ++++
 rtl/rs_oldest_select.sv | 26 ++
 rtl/reservation_station.sv | 185 ++++++++++++++++++
 tb/tb_reservation_station.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: the RS entry record and the CDB broadcast.
package reservation_station_pkg;

    localparam int PREG_AW = 7;
    localparam int XLEN    = 32;
    localparam int ROB_AW  = 4;
    localparam int FU_W    = 2;
    localparam int ALUOP_W = 4;

    typedef struct packed {
        logic               valid;
        logic [PREG_AW-1:0] Dst;
        logic [PREG_AW-1:0] Src0Tag;
        logic [PREG_AW-1:0] Src1Tag;
        logic               Src0Ready;
        logic               Src1Ready;
        logic [XLEN-1:0]    src0;
        logic [XLEN-1:0]    src1;
        logic [XLEN-1:0]    imm;
        logic [ALUOP_W-1:0] ALUOp;
        logic               ALUSrc;
        logic               RegWrite;
        logic               MemRead;
        logic               MemWrite;
        logic               MemtoReg;
        logic [FU_W-1:0]    fu;
        logic [ROB_AW-1:0]  ROBNumber;
    } rs_entry_t;

    typedef struct packed {
        logic               valid;
        logic [PREG_AW-1:0] preg;
        logic [XLEN-1:0]    data;
    } cdb_t;

    function automatic logic tag_hit(input cdb_t c, input logic [PREG_AW-1:0] tag);
        return c.valid && (c.preg == tag);
    endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Oldest-first picker: grants the requesting entry that no other requesting entry is older than.
module rs_oldest_select #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]            req_i,
    input  logic [DEPTH-1:0][DEPTH-1:0] age_i,
    output logic [DEPTH-1:0]            gnt_o
);

    // age_i[j][i] set means entry j is older than entry i
    logic [DEPTH-1:0] blocked;

    always_comb begin
        blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (req_i[j] && age_i[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
    end

    assign gnt_o = req_i & ~blocked;

endmodule

// File: rtl/reservation_station.sv
// Unified reservation station: dispatch into free slots, CDB wakeup, oldest-ready issue per FU.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DISP_W = 2,
    parameter int NUM_FU = 3,
    parameter int CDB_W  = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [DISP_W-1:0]                 i_disp_valid,
    input  rs_entry_t [DISP_W-1:0]            i_disp_entry,
    output logic                              o_disp_ready,
    input  logic [CDB_W-1:0]                  i_cdb_valid,
    input  logic [CDB_W-1:0][PREG_AW-1:0]     i_cdb_preg,
    input  logic [CDB_W-1:0][XLEN-1:0]        i_cdb_data,
    input  logic [NUM_FU-1:0]                 i_fu_ready,
    output logic [NUM_FU-1:0]                 o_issue_valid,
    output rs_entry_t [NUM_FU-1:0]            o_issue_entry,
    input  logic                              i_flush,
    output logic [$clog2(DEPTH):0]            o_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
    rs_entry_t [DEPTH-1:0]       entry_q, entry_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [NUM_FU-1:0]           issue_valid_q, issue_valid_d;
    rs_entry_t [NUM_FU-1:0]      issue_entry_q, issue_entry_d;

    cdb_t [CDB_W-1:0]            cdb;
    logic                        disp_ready;
    logic [DISP_W-1:0]           lane_we;
    logic [DISP_W-1:0][IDX_W-1:0] lane_slot;
    logic [DEPTH-1:0]            taken;
    logic [DEPTH-1:0]            issued;
    logic [DEPTH-1:0]            older;
    logic [CNT_W-1:0]            n_disp, n_iss;
    logic [NUM_FU-1:0][DEPTH-1:0] req, gnt;

    function automatic rs_entry_t wakeup(input rs_entry_t e, input cdb_t [CDB_W-1:0] c);
        rs_entry_t r;
        r = e;
        for (int l = 0; l < CDB_W; l++) begin
            if (!r.Src0Ready && tag_hit(c[l], r.Src0Tag)) begin
                r.Src0Ready = 1'b1;
                r.src0      = c[l].data;
            end
            if (!r.Src1Ready && tag_hit(c[l], r.Src1Tag)) begin
                r.Src1Ready = 1'b1;
                r.src1      = c[l].data;
            end
        end
        return r;
    endfunction

    // p0 is hardwired ready, so it never waits on a broadcast
    function automatic rs_entry_t accept(input rs_entry_t e);
        rs_entry_t r;
        r           = e;
        r.valid     = 1'b1;
        r.Src0Ready = e.Src0Ready || (e.Src0Tag == '0);
        r.Src1Ready = e.Src1Ready || (e.Src1Tag == '0);
        return r;
    endfunction

    always_comb begin
        for (int l = 0; l < CDB_W; l++) begin
            cdb[l] = '{valid: i_cdb_valid[l], preg: i_cdb_preg[l], data: i_cdb_data[l]};
        end
    end

    assign disp_ready = (count_q <= CNT_W'(DEPTH - DISP_W));

    always_comb begin
        taken     = valid_q;
        lane_we   = '0;
        lane_slot = '0;
        for (int l = 0; l < DISP_W; l++) begin
            if (i_disp_valid[l] && disp_ready) begin
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (!taken[i]) lane_slot[l] = IDX_W'(i);
                end
                lane_we[l]            = 1'b1;
                taken[lane_slot[l]]   = 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                req[k][i] = valid_q[i] && entry_q[i].Src0Ready && entry_q[i].Src1Ready &&
                            (entry_q[i].fu == FU_W'(k)) && i_fu_ready[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_FU; k++) begin : g_sel
        rs_oldest_select #(.DEPTH(DEPTH)) u_sel (
            .req_i (req[k]),
            .age_i (age_q),
            .gnt_o (gnt[k])
        );
    end

    always_comb begin
        issued = '0;
        for (int k = 0; k < NUM_FU; k++) issued = issued | gnt[k];

        valid_d = valid_q & ~issued;
        age_d   = age_q;
        for (int i = 0; i < DEPTH; i++) entry_d[i] = wakeup(entry_q[i], cdb);

        for (int i = 0; i < DEPTH; i++) begin
            if (issued[i]) begin
                age_d[i] = '0;
                for (int j = 0; j < DEPTH; j++) age_d[j][i] = 1'b0;
            end
        end

        // each new entry is younger than every survivor and every lower dispatch lane
        older  = valid_q & ~issued;
        n_disp = '0;
        for (int l = 0; l < DISP_W; l++) begin
            if (lane_we[l]) begin
                entry_d[lane_slot[l]] = wakeup(accept(i_disp_entry[l]), cdb);
                valid_d[lane_slot[l]] = 1'b1;
                age_d[lane_slot[l]]   = '0;
                for (int j = 0; j < DEPTH; j++) age_d[j][lane_slot[l]] = older[j];
                older[lane_slot[l]]   = 1'b1;
                n_disp                = n_disp + CNT_W'(1);
            end
        end

        n_iss = '0;
        for (int i = 0; i < DEPTH; i++) n_iss = n_iss + CNT_W'(issued[i]);
        count_d = count_q + n_disp - n_iss;

        issue_entry_d = issue_entry_q;
        for (int k = 0; k < NUM_FU; k++) begin
            issue_valid_d[k] = |gnt[k];
            for (int i = 0; i < DEPTH; i++) begin
                if (gnt[k][i]) issue_entry_d[k] = entry_q[i];
            end
        end

        if (i_flush) begin
            valid_d       = '0;
            count_d       = '0;
            issue_valid_d = '0;
            issue_entry_d = issue_entry_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q       <= '0;
            age_q         <= '0;
            count_q       <= '0;
            issue_valid_q <= '0;
            issue_entry_q <= '0;
        end else begin
            valid_q       <= valid_d;
            age_q         <= age_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_entry_q <= issue_entry_d;
        end
    end

    always_ff @(posedge i_clk) begin
        entry_q <= entry_d;
    end

    assign o_disp_ready  = disp_ready;
    assign o_issue_valid = issue_valid_q;
    assign o_issue_entry = issue_entry_q;
    assign o_count       = count_q;

endmodule

// File: tb/tb_reservation_station.sv
// Randomised and directed bench for reservation_station against an age-ordered queue model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DISP_W = 2;
    localparam int NUM_FU = 3;
    localparam int CDB_W  = 2;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic [DISP_W-1:0]             disp_valid;
    rs_entry_t [DISP_W-1:0]        disp_entry;
    logic                          disp_ready;
    logic [CDB_W-1:0]              cdb_valid;
    logic [CDB_W-1:0][PREG_AW-1:0] cdb_preg;
    logic [CDB_W-1:0][XLEN-1:0]    cdb_data;
    logic [NUM_FU-1:0]             fu_ready;
    logic [NUM_FU-1:0]             issue_valid;
    rs_entry_t [NUM_FU-1:0]        issue_entry;
    logic                          flush;
    logic [CNT_W-1:0]              count;

    reservation_station #(.DEPTH(DEPTH), .DISP_W(DISP_W), .NUM_FU(NUM_FU), .CDB_W(CDB_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_disp_valid  (disp_valid),
        .i_disp_entry  (disp_entry),
        .o_disp_ready  (disp_ready),
        .i_cdb_valid   (cdb_valid),
        .i_cdb_preg    (cdb_preg),
        .i_cdb_data    (cdb_data),
        .i_fu_ready    (fu_ready),
        .o_issue_valid (issue_valid),
        .o_issue_entry (issue_entry),
        .i_flush       (flush),
        .o_count       (count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: queue front is the oldest op
    rs_entry_t         mq[$];
    logic [NUM_FU-1:0] exp_iv;
    rs_entry_t         exp_ie[NUM_FU];

    function automatic rs_entry_t m_wake(input rs_entry_t e);
        rs_entry_t r;
        r = e;
        for (int l = 0; l < CDB_W; l++) begin
            if (cdb_valid[l] && !r.Src0Ready && cdb_preg[l] == r.Src0Tag) begin
                r.Src0Ready = 1'b1; r.src0 = cdb_data[l];
            end
            if (cdb_valid[l] && !r.Src1Ready && cdb_preg[l] == r.Src1Tag) begin
                r.Src1Ready = 1'b1; r.src1 = cdb_data[l];
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_iv = '0;
        for (int k = 0; k < NUM_FU; k++) exp_ie[k] = '0;
    endtask

    task automatic model_edge();
        bit        rdy;
        rs_entry_t e;
        rdy = (mq.size() <= DEPTH - DISP_W);
        if (flush) begin
            mq.delete();
            exp_iv = '0;
            return;
        end
        exp_iv = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (fu_ready[k]) begin
                for (int q = 0; q < mq.size(); q++) begin
                    if (mq[q].Src0Ready && mq[q].Src1Ready && mq[q].fu == FU_W'(k)) begin
                        exp_iv[k] = 1'b1;
                        exp_ie[k] = mq[q];
                        mq.delete(q);
                        break;
                    end
                end
            end
        end
        for (int q = 0; q < mq.size(); q++) mq[q] = m_wake(mq[q]);
        if (rdy) begin
            for (int l = 0; l < DISP_W; l++) begin
                if (disp_valid[l]) begin
                    e = disp_entry[l];
                    e.valid = 1'b1;
                    if (e.Src0Tag == '0) e.Src0Ready = 1'b1;
                    if (e.Src1Tag == '0) e.Src1Ready = 1'b1;
                    mq.push_back(m_wake(e));
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("count", count, mq.size());
        chk("disp_ready", disp_ready, (mq.size() <= DEPTH - DISP_W));
        chk("issue_valid", issue_valid, exp_iv);
        for (int k = 0; k < NUM_FU; k++) chk("issue_entry", issue_entry[k], exp_ie[k]);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        disp_valid = '0;
        cdb_valid  = '0;
        flush      = 1'b0;
    endtask

    function automatic rs_entry_t mk(input int rob, input int fu, input int t0, input bit r0,
                                     input int t1, input bit r1);
        rs_entry_t e;
        e           = '0;
        e.valid     = 1'b1;
        e.Dst       = PREG_AW'($urandom_range(1, 127));
        e.Src0Tag   = PREG_AW'(t0);
        e.Src1Tag   = PREG_AW'(t1);
        e.Src0Ready = r0;
        e.Src1Ready = r1;
        e.src0      = $urandom;
        e.src1      = $urandom;
        e.imm       = $urandom;
        e.ALUOp     = ALUOP_W'($urandom);
        e.ALUSrc    = 1'($urandom);
        e.RegWrite  = 1'($urandom);
        e.MemRead   = 1'($urandom);
        e.MemWrite  = 1'($urandom);
        e.MemtoReg  = 1'($urandom);
        e.fu        = FU_W'(fu);
        e.ROBNumber = ROB_AW'(rob);
        return e;
    endfunction

    function automatic int rtag();
        return ($urandom_range(0, 3) == 0) ? 0 : 40 + int'($urandom_range(0, 7));
    endfunction

    initial begin
        int t;
        idle();
        fu_ready   = '1;
        disp_entry = '0;
        cdb_preg   = '0;
        cdb_data   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_ready", disp_ready, 1'b1);
        chk("rst_iv", issue_valid, 0);
        rst_n = 1'b1;

        // two ready ALU ops: ROB3 then ROB4 on fu0
        disp_valid    = 2'b11;
        disp_entry[0] = mk(3, 0, 10, 1, 11, 1);
        disp_entry[1] = mk(4, 0, 12, 1, 13, 1);
        cycle();
        idle();
        cycle();
        chk("t2_iv0", issue_valid[0], 1'b1);
        chk("t2_rob3", issue_entry[0].ROBNumber, 3);
        cycle();
        chk("t2_rob4", issue_entry[0].ROBNumber, 4);
        cycle();

        // wait on p40, wake a cycle later
        disp_valid    = 2'b01;
        disp_entry[0] = mk(5, 1, 40, 0, 0, 0);
        cycle();
        idle();
        cdb_valid = 2'b01; cdb_preg[0] = 7'd40; cdb_data[0] = 32'hDEADBEEF;
        cycle();
        chk("t3_not_yet", issue_valid[1], 1'b0);
        idle();
        cycle();
        chk("t3_iv1", issue_valid[1], 1'b1);
        chk("t3_src0", issue_entry[1].src0, 32'hDEADBEEF);

        // dispatch and broadcast of p41 in the same cycle
        disp_valid    = 2'b01;
        disp_entry[0] = mk(6, 2, 3, 1, 41, 0);
        cdb_valid = 2'b10; cdb_preg[1] = 7'd41; cdb_data[1] = 32'h0BAD_F00D;
        cycle();
        idle();
        cycle();
        chk("t4_iv2", issue_valid[2], 1'b1);
        chk("t4_src1", issue_entry[2].src1, 32'h0BAD_F00D);

        // fill to 15, stall, then one issue reopens dispatch
        fu_ready = '0;
        for (int c = 0; c < 7; c++) begin
            disp_valid    = 2'b11;
            disp_entry[0] = (c == 0) ? mk(7, 1, 0, 1, 0, 1) : mk(8, 0, 50, 0, 0, 1);
            disp_entry[1] = mk(9, 2, 50, 0, 51, 0);
            cycle();
        end
        disp_valid    = 2'b01;
        disp_entry[0] = mk(10, 0, 50, 0, 0, 1);
        cycle();
        chk("t5_full_ready", disp_ready, 1'b0);
        chk("t5_full_count", count, 15);
        disp_valid = 2'b11;
        cycle();
        chk("t5_ignored", count, 15);
        idle();
        fu_ready = '1;
        cycle();
        chk("t5_reopen", disp_ready, 1'b1);
        flush = 1'b1;
        cycle();
        idle();

        // flush with 8 held entries and a same-cycle dispatch
        fu_ready = '0;
        for (int c = 0; c < 4; c++) begin
            disp_valid    = 2'b11;
            disp_entry[0] = mk(c, c % 3, 0, 1, 0, 1);
            disp_entry[1] = mk(c + 8, 1, 0, 1, 0, 1);
            cycle();
        end
        chk("t6_count8", count, 8);
        fu_ready      = '1;
        flush         = 1'b1;
        disp_valid    = 2'b11;
        disp_entry[0] = mk(12, 0, 0, 1, 0, 1);
        cycle();
        chk("t6_count0", count, 0);
        chk("t6_noissue", issue_valid, 0);
        idle();

        // async reset with 5 entries held
        fu_ready = '0;
        for (int c = 0; c < 5; c++) begin
            disp_valid    = 2'b01;
            disp_entry[0] = mk(c, 0, 0, 1, 0, 1);
            cycle();
        end
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_count", count, 0);
        chk("t1_iv", issue_valid, 0);
        chk("t1_ready", disp_ready, 1'b1);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // randomised traffic
        for (int c = 0; c < 600; c++) begin
            for (int l = 0; l < DISP_W; l++) begin
                disp_valid[l] = ($urandom_range(0, 99) < 45);
                disp_entry[l] = mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                                   rtag(), 1'($urandom), rtag(), 1'($urandom));
            end
            t = int'($urandom_range(0, 7));
            cdb_valid   = CDB_W'($urandom);
            cdb_preg[0] = PREG_AW'(40 + t);
            cdb_preg[1] = PREG_AW'(40 + ((t + 1 + int'($urandom_range(0, 6))) % 8));
            cdb_data[0] = $urandom;
            cdb_data[1] = $urandom;
            for (int k = 0; k < NUM_FU; k++) fu_ready[k] = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 99) < 2);
            cycle();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
